// File: rtl/reset_sequencer.sv
// Staged reset controller: holds NUM_STAGES domains in reset, then releases
// them in index order, waiting for each stage's ready ack between releases.
//
// Ports:
//   clk, resetn        system clock, synchronous active-low reset
//   stimuli_valid      stimulus valid; its rising edge qualifies do_reset
//   do_reset           reset request, taken on rising stimuli_valid
//   sw_req             single-cycle software reset request
//   stage_ready        per-stage ready ack
//   stage_resetn       per-stage active-low reset (registered)
//   busy               high while a sequence is in progress
//   seq_done           one-cycle pulse once the last stage is acked
//   timeout_err        sticky; a stage failed to ack in time
//   stage_idx          stage currently being released/awaited
module reset_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned ASSERT_CYCLES  = 15,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stimuli_valid,
  input  logic                  do_reset,
  input  logic                  sw_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] stage_idx
);

  localparam int unsigned IDX_W =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned CNT_MAX =
    (ASSERT_CYCLES > GAP_CYCLES) ? ASSERT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned TCNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [TCNT_W-1:0] tcnt_t;

  localparam idx_t  IDX_LAST   = idx_t'(NUM_STAGES - 1);
  localparam cnt_t  CNT_ASSERT = cnt_t'(ASSERT_CYCLES - 1);
  localparam cnt_t  CNT_GAP    = cnt_t'(GAP_CYCLES - 1);
  localparam tcnt_t TCNT_LAST  = tcnt_t'(TIMEOUT_CYCLES - 1);
  localparam bit    TMO_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_IDLE
  } state_t;

  state_t                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  tcnt_t                 tcnt_q, tcnt_d;
  idx_t                  idx_q, idx_d;
  logic [NUM_STAGES-1:0] srn_q, srn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  terr_q, terr_d;
  logic                  sv_q;

  logic trig;
  logic rdy;
  logic tmo;
  idx_t idx_nxt;

  assign trig    = (stimuli_valid & ~sv_q & do_reset) | sw_req;
  assign rdy     = stage_ready[idx_q];
  assign tmo     = TMO_EN && !rdy && (tcnt_q == TCNT_LAST);
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    srn_d   = srn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    if (trig) begin
      // A trigger beats every in-flight event, including ASSERT itself.
      state_d = S_ASSERT;
      cnt_d   = CNT_ASSERT;
      idx_d   = '0;
      srn_d   = '0;
      busy_d  = 1'b1;
      terr_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            srn_d[0] = 1'b1;
            tcnt_d   = '0;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (rdy || tmo) begin
            if (tmo) terr_d = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = CNT_GAP;
            end
          end else if (TMO_EN) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            idx_d          = idx_nxt;
            srn_d[idx_nxt] = 1'b1;
            tcnt_d         = '0;
            state_d        = S_WAIT;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_ASSERT;
          cnt_d   = CNT_ASSERT;
          idx_d   = '0;
          srn_d   = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_ASSERT;
      cnt_q   <= CNT_ASSERT;
      tcnt_q  <= '0;
      idx_q   <= '0;
      srn_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      srn_q   <= srn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      sv_q    <= stimuli_valid;
    end
  end

  assign stage_resetn = srn_q;
  assign busy         = busy_q;
  assign seq_done     = done_q;
  assign timeout_err  = terr_q;
  assign stage_idx    = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random stimulus,
// checked every cycle against a timeline model of release/ack times.
module tb_reset_sequencer;

  localparam int N = 4;
  localparam int A = 15;
  localparam int G = 8;
  localparam int T = 255;

  logic         clk = 1'b0;
  logic         resetn;
  logic         stimuli_valid;
  logic         do_reset;
  logic         sw_req;
  logic [N-1:0] stage_ready;
  logic [N-1:0] stage_resetn;
  logic         busy;
  logic         seq_done;
  logic         timeout_err;
  logic [1:0]   stage_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES(N),
    .ASSERT_CYCLES(A),
    .GAP_CYCLES(G),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .stimuli_valid(stimuli_valid),
    .do_reset(do_reset),
    .sw_req(sw_req),
    .stage_ready(stage_ready),
    .stage_resetn(stage_resetn),
    .busy(busy),
    .seq_done(seq_done),
    .timeout_err(timeout_err),
    .stage_idx(stage_idx)
  );

  // Timeline model: absolute edge numbers of trigger, release and ack.
  int ecnt  = 0;
  int t_trig = 0;
  int t_rel  = 0;
  int t_ack  = 0;
  int n_rel  = 0;
  bit acked  = 0;
  bit terr_m = 0;
  bit sv_d_m = 0;

  // Edge markers taken from the DUT, pinned to hand-computed literals.
  int rise_edge[N];
  int done_edge, bfall_edge, terr_edge;
  logic [N-1:0] p_srn;
  logic p_busy, p_done, p_terr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at edge %0d",
               name, act, exp, ecnt);
    end
  endtask

  task automatic model_edge();
    bit trig;
    ecnt++;
    trig = (stimuli_valid && !sv_d_m && do_reset) || sw_req;
    sv_d_m = resetn ? stimuli_valid : 1'b0;
    if (!resetn || trig) begin
      t_trig = ecnt;
      n_rel  = 0;
      acked  = 0;
      terr_m = 0;
    end else if (n_rel == 0) begin
      if (ecnt - t_trig == A) begin
        n_rel = 1;
        t_rel = ecnt;
      end
    end else if (!acked) begin
      if (stage_ready[n_rel-1]) begin
        acked = 1;
        t_ack = ecnt;
      end else if (T != 0 && ecnt - t_rel == T) begin
        terr_m = 1;
        acked  = 1;
        t_ack  = ecnt;
      end
    end else if (n_rel < N && ecnt - t_ack == G) begin
      n_rel++;
      t_rel = ecnt;
      acked = 0;
    end
  endtask

  task automatic clear_marks();
    foreach (rise_edge[k]) rise_edge[k] = -1;
    done_edge  = -1;
    bfall_edge = -1;
    terr_edge  = -1;
  endtask

  task automatic step();
    bit fin;
    @(posedge clk);
    model_edge();
    #1;
    fin = acked && (n_rel == N);
    chk("stage_resetn", stage_resetn, (1 << n_rel) - 1);
    chk("stage_idx", stage_idx, (n_rel == 0) ? 0 : n_rel - 1);
    chk("busy", busy, !(fin && ecnt > t_ack));
    chk("seq_done", seq_done, fin && ecnt == t_ack);
    chk("timeout_err", timeout_err, terr_m);
    for (int k = 0; k < N; k++)
      if (!p_srn[k] && stage_resetn[k] && rise_edge[k] < 0)
        rise_edge[k] = ecnt;
    if (!p_done && seq_done && done_edge < 0) done_edge = ecnt;
    if (p_busy && !busy && bfall_edge < 0) bfall_edge = ecnt;
    if (!p_terr && timeout_err && terr_edge < 0) terr_edge = ecnt;
    p_srn  = stage_resetn;
    p_busy = busy;
    p_done = seq_done;
    p_terr = timeout_err;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int base;
  int guard;

  initial begin
    resetn        = 1'b0;
    stimuli_valid = 1'b0;
    do_reset      = 1'b0;
    sw_req        = 1'b0;
    stage_ready   = '1;
    p_srn = '0; p_busy = 1'b1; p_done = 1'b0; p_terr = 1'b0;
    clear_marks();

    // 1: power-up with all ready tied high.
    run(3);
    chk("rst_srn", stage_resetn, 0);
    chk("rst_busy", busy, 1);
    chk("rst_idx", stage_idx, 0);
    base = ecnt;
    resetn = 1'b1;
    clear_marks();
    run(60);
    for (int k = 0; k < N; k++)
      chk("pu_rise", rise_edge[k] - base, 15 + 9 * k);
    chk("pu_done", done_edge - base, 43);
    chk("pu_bfall", bfall_edge - base, 44);

    // 2: stimulus-requested reset.
    stimuli_valid = 1'b1;
    do_reset      = 1'b0;
    run(3);
    chk("dr0_busy", busy, 0);
    stimuli_valid = 1'b0;
    step();
    stimuli_valid = 1'b1;
    do_reset      = 1'b1;
    clear_marks();
    step();
    base = ecnt;
    chk("dr_srn", stage_resetn, 0);
    chk("dr_busy", busy, 1);
    run(60);
    chk("dr_done", done_edge - base, 43);
    stimuli_valid = 1'b0;
    do_reset      = 1'b0;

    // 3: stage 2 never acks.
    stage_ready = 4'b1011;
    sw_req = 1'b1;
    clear_marks();
    step();
    base = ecnt;
    sw_req = 1'b0;
    run(320);
    chk("to_len", terr_edge - rise_edge[2], 255);
    chk("to_gap", rise_edge[3] - terr_edge, 8);
    chk("to_done", done_edge - base, 297);
    chk("to_sticky", timeout_err, 1);
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    chk("to_clr", timeout_err, 0);

    // 4: sw_req mid-GAP of stage 1, then sw_req racing a ready.
    stage_ready = '1;
    guard = 0;
    while (!(n_rel == 2 && acked) && guard < 100) begin
      step();
      guard++;
    end
    chk("wait_gap1", n_rel == 2 && acked, 1);
    run(3);
    sw_req = 1'b1;
    clear_marks();
    step();
    base = ecnt;
    sw_req = 1'b0;
    chk("gap_srn", stage_resetn, 0);
    chk("gap_idx", stage_idx, 0);
    stage_ready = '0;
    run(20);
    chk("gap_rel", rise_edge[0] - base, 15);
    run(2);
    stage_ready = '1;
    sw_req      = 1'b1;
    step();
    sw_req = 1'b0;
    chk("race_srn", stage_resetn, 0);
    chk("race_busy", busy, 1);

    // 5: resetn pulse during WAIT of stage 3.
    stage_ready = 4'b0111;
    guard = 0;
    while (!(n_rel == 4 && !acked) && guard < 100) begin
      step();
      guard++;
    end
    chk("wait_s3", n_rel == 4 && !acked, 1);
    run(3);
    resetn = 1'b0;
    step();
    chk("r5_srn", stage_resetn, 0);
    chk("r5_idx", stage_idx, 0);
    chk("r5_busy", busy, 1);
    resetn = 1'b1;
    stage_ready = '1;
    clear_marks();
    base = ecnt;
    run(50);
    chk("r5_done", done_edge - base, 43);

    // 6: repeated sw_req every 10 cycles.
    for (int i = 0; i < 4; i++) begin
      sw_req = 1'b1;
      step();
      base = ecnt;
      sw_req = 1'b0;
      clear_marks();
      run(9);
    end
    run(11);
    chk("rep_rel", rise_edge[0] - base, 15);

    // 7: random traffic.
    for (int i = 0; i < 4000; i++) begin
      stage_ready = N'($urandom) & N'($urandom) & N'($urandom);
      sw_req      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) stimuli_valid = ~stimuli_valid;
      do_reset    = $urandom_range(0, 1) == 1;
      resetn      = ($urandom_range(0, 999) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
